// File: rtl/regfile_wb_if.sv
// Bundle between the issue stage, the ALU/LSU writeback paths and the
// register-file write port, as seen by the writeback scheduler.
interface regfile_wb_if;
    logic        iss_valid;
    logic        iss_wr;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        w_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pending;
    logic        sb_err;

    modport master (
        output iss_valid, iss_wr, iss_rd, iss_rs1, iss_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_stall, alu_ready, w_enable, wb_addr, wb_data, pending, sb_err
    );

    modport slave (
        input  iss_valid, iss_wr, iss_rd, iss_rs1, iss_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_stall, alu_ready, w_enable, wb_addr, wb_data, pending, sb_err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: merges LSU and ALU (via one-entry skid buffer) onto the
// single register-file write port and keeps a scoreboard that stalls hazards.
module regfile_wb_sched (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);

    logic        w_enable_r;
    logic [4:0]  wb_addr_r;
    logic [31:0] wb_data_r;
    logic [31:0] pending_r;
    logic        sb_err_r;
    logic        buf_full_r;
    logic [4:0]  buf_rd_r;
    logic [31:0] buf_data_r;

    logic        alu_ready_s;
    logic        alu_acc_s;
    logic        sel_valid_s;
    logic [4:0]  sel_rd_s;
    logic [31:0] sel_data_s;
    logic        buf_load_s;
    logic        buf_drain_s;
    logic        iss_stall_s;
    logic        iss_acc_s;
    logic        err_set_s;
    logic [31:0] pending_nxt_s;

    // A register committing this cycle is forwarded by the file, so it is not busy.
    function automatic logic is_busy(input logic [4:0]  r,
                                     input logic [31:0] pend,
                                     input logic        we,
                                     input logic [4:0]  wa);
        is_busy = pend[r] && !(we && (wa == r));
    endfunction

    assign alu_ready_s = rst && !buf_full_r;
    assign alu_acc_s   = bus.alu_valid && alu_ready_s;

    // Write-source selection: LSU, then skid buffer, then direct ALU.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_rd_s    = 5'd0;
        sel_data_s  = 32'd0;
        buf_load_s  = 1'b0;
        buf_drain_s = 1'b0;
        if (bus.lsu_valid) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = bus.lsu_rd;
            sel_data_s  = bus.lsu_data;
            buf_load_s  = alu_acc_s;
        end else if (buf_full_r) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = buf_rd_r;
            sel_data_s  = buf_data_r;
            buf_drain_s = 1'b1;
        end else if (alu_acc_s) begin
            sel_valid_s = 1'b1;
            sel_rd_s    = bus.alu_rd;
            sel_data_s  = bus.alu_data;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Hazard check, issue acceptance and scoreboard next state (set beats clear).
    always_comb begin
        iss_stall_s = bus.iss_valid &&
                      (((bus.iss_rs1 != 5'd0) && is_busy(bus.iss_rs1, pending_r, w_enable_r, wb_addr_r)) ||
                       ((bus.iss_rs2 != 5'd0) && is_busy(bus.iss_rs2, pending_r, w_enable_r, wb_addr_r)) ||
                       (bus.iss_wr && (bus.iss_rd != 5'd0) &&
                        is_busy(bus.iss_rd, pending_r, w_enable_r, wb_addr_r)));
        iss_acc_s   = bus.iss_valid && !iss_stall_s;
        err_set_s   = sel_valid_s && (sel_rd_s != 5'd0) && !pending_r[sel_rd_s];
        pending_nxt_s = pending_r;
        if (w_enable_r) begin
            pending_nxt_s[wb_addr_r] = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        if (iss_acc_s && bus.iss_wr && (bus.iss_rd != 5'd0)) begin
            pending_nxt_s[bus.iss_rd] = 1'b1;
        end else begin
            pending_nxt_s[0] = 1'b0;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Write-port register; rd=0 writes are consumed without a strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_enable_r <= 1'b0;
            wb_addr_r  <= 5'd0;
            wb_data_r  <= 32'd0;
        end else if (sel_valid_s) begin
            w_enable_r <= (sel_rd_s != 5'd0);
            wb_addr_r  <= sel_rd_s;
            wb_data_r  <= sel_data_s;
        end else begin
            w_enable_r <= 1'b0;
        end
    end

    // Skid buffer holding an ALU result displaced by the LSU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_full_r <= 1'b0;
            buf_rd_r   <= 5'd0;
            buf_data_r <= 32'd0;
        end else if (buf_load_s) begin
            buf_full_r <= 1'b1;
            buf_rd_r   <= bus.alu_rd;
            buf_data_r <= bus.alu_data;
        end else if (buf_drain_s) begin
            buf_full_r <= 1'b0;
        end else begin
            buf_full_r <= buf_full_r;
        end
    end

    // Scoreboard and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r <= 32'd0;
            sb_err_r  <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            sb_err_r  <= sb_err_r || err_set_s;
        end
    end

    assign bus.iss_stall = iss_stall_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.w_enable  = w_enable_r;
    assign bus.wb_addr   = wb_addr_r;
    assign bus.wb_data   = wb_data_r;
    assign bus.pending   = pending_r;
    assign bus.sb_err    = sb_err_r;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: one vector per clock cycle, followed by
// a hand-written reset-while-buffered sequence.
module tb_regfile_wb_sched;

    logic clk;
    logic rst;
    regfile_wb_if bus();

    regfile_wb_sched dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        iw;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_stall;
        logic        e_ar;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_pend;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic iv, input logic iw,
                       input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic es, input logic ea, input logic ew,
                       input logic [4:0] eaddr, input logic [31:0] edata,
                       input logic [31:0] epend, input logic eerr);
        vec_t v;
        v.rst = r; v.iv = iv; v.iw = iw; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_stall = es; v.e_ar = ea; v.e_we = ew; v.e_addr = eaddr;
        v.e_data = edata; v.e_pend = epend; v.e_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.iss_valid = v.iv;  bus.iss_wr  = v.iw;  bus.iss_rd  = v.ird;
        bus.iss_rs1   = v.rs1; bus.iss_rs2 = v.rs2;
        bus.alu_valid = v.av;  bus.alu_rd  = v.ard; bus.alu_data = v.ad;
        bus.lsu_valid = v.lv;  bus.lsu_rd  = v.lrd; bus.lsu_data = v.ld;
    endtask

    task automatic idle();
        rst = 1'b1;
        bus.iss_valid = 1'b0; bus.iss_wr = 1'b0; bus.iss_rd = 5'd0;
        bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
    endtask

    initial begin
        // rst iv iw ird rs1 rs2 | av ard ad | lv lrd ld | stall ar we addr data pend err
        // reset held two cycles with everything valid
        add(1'b0, 1'b1,1'b1,5'd1,5'd1,5'd2, 1'b1,5'd2,32'h1, 1'b1,5'd3,32'h2, 1'b0,1'b0,1'b0,5'd0,32'h0,32'h0,1'b0);
        add(1'b0, 1'b1,1'b1,5'd1,5'd1,5'd2, 1'b1,5'd2,32'h1, 1'b1,5'd3,32'h2, 1'b0,1'b0,1'b0,5'd0,32'h0,32'h0,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd0,32'h0,32'h0,1'b0);
        // RAW stall on x5, released in the commit cycle
        add(1'b1, 1'b1,1'b1,5'd5,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd0,32'h0,32'h0,1'b0);
        add(1'b1, 1'b1,1'b0,5'd0,5'd5,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,5'd0,32'h0,32'h20,1'b0);
        add(1'b1, 1'b1,1'b0,5'd0,5'd5,5'd0, 1'b1,5'd5,32'h1234, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,5'd0,32'h0,32'h20,1'b0);
        add(1'b1, 1'b1,1'b0,5'd0,5'd5,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,5'd5,32'h1234,32'h20,1'b0);
        // collision: LSU x3 and ALU x4 together
        add(1'b1, 1'b1,1'b1,5'd3,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd5,32'h1234,32'h0,1'b0);
        add(1'b1, 1'b1,1'b1,5'd4,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd5,32'h1234,32'h8,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd4,32'hBBBB, 1'b1,5'd3,32'hAAAA, 1'b0,1'b1,1'b0,5'd5,32'h1234,32'h18,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd6,32'h6666, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,5'd3,32'hAAAA,32'h18,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,5'd4,32'hBBBB,32'h10,1'b0);
        // mark x10..x15 in flight
        add(1'b1, 1'b1,1'b1,5'd10,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'h0,1'b0);
        add(1'b1, 1'b1,1'b1,5'd11,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'h400,1'b0);
        add(1'b1, 1'b1,1'b1,5'd12,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'hC00,1'b0);
        add(1'b1, 1'b1,1'b1,5'd13,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'h1C00,1'b0);
        add(1'b1, 1'b1,1'b1,5'd14,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'h3C00,1'b0);
        add(1'b1, 1'b1,1'b1,5'd15,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'h7C00,1'b0);
        // buffer starvation: ALU x15 buffered behind five LSU writes
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd15,32'hF0, 1'b1,5'd10,32'hA0, 1'b0,1'b1,1'b0,5'd4,32'hBBBB,32'hFC00,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd11,32'hA1, 1'b0,1'b0,1'b1,5'd10,32'hA0,32'hFC00,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd12,32'hA2, 1'b0,1'b0,1'b1,5'd11,32'hA1,32'hF800,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd13,32'hA3, 1'b0,1'b0,1'b1,5'd12,32'hA2,32'hF000,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd14,32'hA4, 1'b0,1'b0,1'b1,5'd13,32'hA3,32'hE000,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b1,5'd14,32'hA4,32'hC000,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,5'd15,32'hF0,32'h8000,1'b0);
        // same-cycle clear and set on x7, then an rd=0 ALU write
        add(1'b1, 1'b1,1'b1,5'd7,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd15,32'hF0,32'h0,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b1,5'd7,32'h77, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd15,32'hF0,32'h80,1'b0);
        add(1'b1, 1'b1,1'b1,5'd7,5'd7,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,5'd7,32'h77,32'h80,1'b0);
        add(1'b1, 1'b1,1'b0,5'd0,5'd7,5'd0, 1'b1,5'd0,32'h55, 1'b0,5'd0,32'h0, 1'b1,1'b1,1'b0,5'd7,32'h77,32'h80,1'b0);
        // spurious LSU writeback to x9
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b1,5'd9,32'h99, 1'b0,1'b1,1'b0,5'd0,32'h55,32'h80,1'b0);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b1,5'd9,32'h99,32'h80,1'b1);
        add(1'b1, 1'b0,1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b1,1'b0,5'd9,32'h99,32'h80,1'b1);

        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("row%0d iss_stall", i), {31'd0, bus.iss_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("row%0d alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].e_ar});
            chk($sformatf("row%0d w_enable", i),  {31'd0, bus.w_enable},  {31'd0, vecs[i].e_we});
            chk($sformatf("row%0d wb_addr", i),   {27'd0, bus.wb_addr},   {27'd0, vecs[i].e_addr});
            chk($sformatf("row%0d wb_data", i),   bus.wb_data,            vecs[i].e_data);
            chk($sformatf("row%0d pending", i),   bus.pending,            vecs[i].e_pend);
            chk($sformatf("row%0d sb_err", i),    {31'd0, bus.sb_err},    {31'd0, vecs[i].e_err});
            @(posedge clk); #1;
        end

        // Reset while an ALU result sits in the skid buffer: it must be discarded.
        idle();
        bus.iss_valid = 1'b1; bus.iss_wr = 1'b1; bus.iss_rd = 5'd20;
        @(negedge clk);
        chk("mid issue x20 stall", {31'd0, bus.iss_stall}, 32'd0);
        @(posedge clk); #1;
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7;  bus.lsu_data = 32'h7A;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
        @(negedge clk);
        chk("mid pending before", bus.pending, 32'h0010_0080);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid alu_ready in reset", {31'd0, bus.alu_ready}, 32'd0);
        chk("mid lsu commit x7", {27'd0, bus.wb_addr}, 32'd7);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("post reset w_enable", {31'd0, bus.w_enable}, 32'd0);
        chk("post reset wb_addr", {27'd0, bus.wb_addr}, 32'd0);
        chk("post reset wb_data", bus.wb_data, 32'd0);
        chk("post reset pending", bus.pending, 32'd0);
        chk("post reset sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("post reset alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("buffer discarded", {31'd0, bus.w_enable}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
